n_bit_down_counter: RTL
=======================

N_BIT_DOWN_COUNTER -- requirements
Module: n_bit_down_counter

Interface
REQ-001 SHALL have parameter: LENGTH, default 3, counter width in bits (LENGTH >= 2).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: en  input  1  count enable; one decrement per enabled RUN cycle.
REQ-005 SHALL have port: load  input  1  synchronous parallel load strobe.
REQ-006 SHALL have port: load_val  input  LENGTH  value captured on load.
REQ-007 SHALL have port: start  input  1  enter RUN from IDLE or DONE.
REQ-008 SHALL have port: stop  input  1  leave RUN, hold count.
REQ-009 SHALL have port: oneshot  input  1  0 = periodic reload on underflow, 1 = stop at zero.
REQ-010 SHALL have port: out  output  LENGTH  current count, registered.
REQ-011 SHALL have port: tc  output  1  terminal-count pulse, registered, one cycle wide.
REQ-012 SHALL have port: busy  output  1  high while state is RUN.
REQ-013 SHALL have port: done  output  1  high while state is DONE.

Function
REQ-014 SHALL implement three states: RUN, IDLE, DONE; busy and done decoded directly from state.
REQ-015 SHALL hold an internal reload register; every load writes load_val to both out and reload register.
REQ-016 SHALL apply per-edge priority: load > stop > start > count.
REQ-017 On load: out <= load_val, no tc; state unchanged, except DONE -> IDLE.
REQ-018 On stop (no load) in RUN: state -> IDLE, out held, tc=0; stop in IDLE/DONE ignored.
REQ-019 On start (no load/stop) in IDLE: state -> RUN, out unchanged; in DONE: state -> RUN, out <= reload register; in RUN ignored.
REQ-020 In RUN with en=0: out held, tc=0.
REQ-021 In RUN with en=1 and out != 0: out <= out - 1, modulo 2^LENGTH never reached.
REQ-022 Underflow event = RUN, en=1, out == 0, no load/stop/start action; tc SHALL be 1 in the cycle after that edge, 0 otherwise.
REQ-023 On underflow with oneshot=0: out <= reload register, state stays RUN.
REQ-024 On underflow with oneshot=1: out stays 0, state -> DONE.
REQ-025 With reload register = 0 and oneshot=0: out stays 0, tc high every cycle while RUN and en=1.
REQ-026 load or stop coincident with an underflow condition SHALL suppress that underflow (no tc, no reload, no DONE).
REQ-027 oneshot SHALL be sampled only at the underflow edge; changes at other times have no effect.
REQ-028 IDLE and DONE SHALL ignore en entirely.

Reset
REQ-029 On rst=1, immediately and independent of clk: out = all ones (2^LENGTH-1), reload register = all ones, state = RUN, tc = 0, busy = 1, done = 0.
REQ-030 Reset asserted mid-count or in DONE SHALL discard all prior state; first edge after release with en=1 SHALL give out = 2^LENGTH-2.
REQ-031 With all inputs except en held low, out SHALL free-run down 7,6,...,0,7,... (LENGTH=3), mirror of the up counter.

Verification (LENGTH=3)
REQ-032 Free run: rst pulse, en=1, others 0 -> out 7,6,5,4,3,2,1,0,7; tc=1 exactly in the cycle out shows the second 7; busy=1 throughout.
REQ-033 One-shot: load_val=4 with load, oneshot=1, en=1 -> out 4,3,2,1,0, then 0 held, done=1, busy=0, single tc pulse; start -> out=4, busy=1.
REQ-034 Stop/resume: stop when out=5 -> out holds 5 for 3 cycles, busy=0, tc=0; start -> RUN, next enabled edge out=4.
REQ-035 Collision: out=0, en=1, load=1, load_val=2 same edge -> out=2, tc=0, state RUN; stop instead of load -> out=0, IDLE, tc=0.
REQ-036 Async reset: assert rst between clock edges while out=3 in RUN -> out=7, tc=0, done=0 before next rising edge.
REQ-037 Zero reload: load_val=0, oneshot=0, en=1 -> out=0 steady, tc=1 every cycle; en=0 -> tc=0 next cycle.

Source files
------------

// File: rtl/n_bit_down_counter.sv
// Down counter with parallel load, start/stop control and a one-shot or periodic
// reload on underflow. tc is a registered single-cycle pulse marking each underflow.
module n_bit_down_counter #(
    parameter int LENGTH = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [LENGTH-1:0] load_val,
    input  logic              start,
    input  logic              stop,
    input  logic              oneshot,
    output logic [LENGTH-1:0] out,
    output logic              tc,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        IDLE = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [LENGTH-1:0] reload, reload_n;
    logic [LENGTH-1:0] out_n;
    logic              tc_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= RUN;
            out    <= '1;
            reload <= '1;
            tc     <= 1'b0;
        end else begin
            state  <= state_n;
            out    <= out_n;
            reload <= reload_n;
            tc     <= tc_n;
        end
    end

    // Priority chain: load > stop > start > count. A stop that arrives outside RUN
    // still wins the chain, so it also blocks a coincident start.
    always_comb begin
        state_n  = state;
        out_n    = out;
        reload_n = reload;
        tc_n     = 1'b0;
        if (load) begin
            out_n    = load_val;
            reload_n = load_val;
            if (state == DONE)
                state_n = IDLE;
        end else if (stop) begin
            if (state == RUN)
                state_n = IDLE;
        end else if (start && state != RUN) begin
            state_n = RUN;
            if (state == DONE)
                out_n = reload;
        end else if (state == RUN && en) begin
            if (out != '0) begin
                out_n = out - LENGTH'(1);
            end else begin
                tc_n = 1'b1;
                if (oneshot)
                    state_n = DONE;
                else
                    out_n = reload;
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
